// File: rtl/multicycle_cpu.sv
// Multicycle accumulator-style CPU: FETCH / EXECUTE / HALT sequencing with an 8-entry register file.
// Optional macro COND_BRANCH_EN enables the JZ/JC conditional jumps (otherwise they behave as NOP).
module multicycle_cpu #(
    parameter int REGISTER_WIDTH      = 8,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter int PC_WIDTH            = 8,
    localparam int REG_ADDR_WIDTH     = $clog2(NUMBER_OF_REGISTERS),
    localparam int INSTRUCTION_WIDTH  = 4 + 2 * REG_ADDR_WIDTH + REGISTER_WIDTH
) (
    input  logic                         clock,
    input  logic                         isReset,
    output logic                         instrRequest,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic                         instrValid,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic [REGISTER_WIDTH-1:0]    switch,
    input  logic [REG_ADDR_WIDTH-1:0]    debugSelect,
    output logic [REGISTER_WIDTH-1:0]    register1Value,
    output logic                         zeroFlag,
    output logic                         carryFlag,
    output logic                         halted
);

    localparam logic [3:0] OP_LOAD       = 4'd1;
    localparam logic [3:0] OP_LOADSWITCH = 4'd2;
    localparam logic [3:0] OP_ADD        = 4'd3;
    localparam logic [3:0] OP_INC        = 4'd4;
    localparam logic [3:0] OP_DECREMENT  = 4'd5;
    localparam logic [3:0] OP_LSHIFT     = 4'd6;
    localparam logic [3:0] OP_RSHIFT     = 4'd7;
    localparam logic [3:0] OP_JUMP       = 4'd8;
    localparam logic [3:0] OP_JUMPREG    = 4'd9;
    localparam logic [3:0] OP_JZ         = 4'd10;
    localparam logic [3:0] OP_JC         = 4'd11;
    localparam logic [3:0] OP_HALT       = 4'd15;

    localparam logic [REGISTER_WIDTH:0] ONE_EXT = {{REGISTER_WIDTH{1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0]     PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t                         state_r;
    logic [INSTRUCTION_WIDTH-1:0]   instr_r;
    logic [REGISTER_WIDTH-1:0]      registers_r [NUMBER_OF_REGISTERS];

    logic [3:0]                     opCode_s;
    logic [REG_ADDR_WIDTH-1:0]      rd_s;
    logic [REG_ADDR_WIDTH-1:0]      rs_s;
    logic [REGISTER_WIDTH-1:0]      imm_s;
    logic [REGISTER_WIDTH-1:0]      rdValue_s;
    logic [REGISTER_WIDTH-1:0]      rsValue_s;
    logic [REGISTER_WIDTH:0]        result_s;
    logic                           writeEn_s;
    logic                           flagEn_s;
    logic                           isHalt_s;
    logic [PC_WIDTH-1:0]            nextPc_s;

    assign opCode_s  = instr_r[INSTRUCTION_WIDTH-1 -: 4];
    assign rd_s      = instr_r[INSTRUCTION_WIDTH-5 -: REG_ADDR_WIDTH];
    assign rs_s      = instr_r[INSTRUCTION_WIDTH-5-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
    assign imm_s     = instr_r[REGISTER_WIDTH-1:0];
    assign rdValue_s = registers_r[rd_s];
    assign rsValue_s = registers_r[rs_s];

    // Register 0 is never written, so a plain index already reads it as zero.
    assign register1Value = registers_r[debugSelect];

    // Decode and ALU: result_s[MSB] carries carry-out, borrow or the shifted-out bit.
    always_comb begin
        result_s  = '0;
        writeEn_s = 1'b0;
        flagEn_s  = 1'b0;
        isHalt_s  = 1'b0;
        nextPc_s  = pc + PC_ONE;
        case (opCode_s)
            OP_LOAD: begin
                result_s  = {1'b0, imm_s};
                writeEn_s = 1'b1;
            end
            OP_LOADSWITCH: begin
                result_s  = {1'b0, switch};
                writeEn_s = 1'b1;
            end
            OP_ADD: begin
                result_s  = {1'b0, rdValue_s} + {1'b0, rsValue_s};
                writeEn_s = 1'b1;
                flagEn_s  = 1'b1;
            end
            OP_INC: begin
                result_s  = {1'b0, rsValue_s} + ONE_EXT;
                writeEn_s = 1'b1;
                flagEn_s  = 1'b1;
            end
            OP_DECREMENT: begin
                result_s  = {1'b0, rsValue_s} - ONE_EXT;
                writeEn_s = 1'b1;
                flagEn_s  = 1'b1;
            end
            OP_LSHIFT: begin
                result_s  = {rsValue_s, 1'b0};
                writeEn_s = 1'b1;
                flagEn_s  = 1'b1;
            end
            OP_RSHIFT: begin
                result_s  = {rsValue_s[0], 1'b0, rsValue_s[REGISTER_WIDTH-1:1]};
                writeEn_s = 1'b1;
                flagEn_s  = 1'b1;
            end
            OP_JUMP:    nextPc_s = PC_WIDTH'(imm_s);
            OP_JUMPREG: nextPc_s = PC_WIDTH'(rsValue_s);
`ifdef COND_BRANCH_EN
            OP_JZ: begin
                if (zeroFlag) begin
                    nextPc_s = PC_WIDTH'(imm_s);
                end else begin
                    nextPc_s = pc + PC_ONE;
                end
            end
            OP_JC: begin
                if (carryFlag) begin
                    nextPc_s = PC_WIDTH'(imm_s);
                end else begin
                    nextPc_s = pc + PC_ONE;
                end
            end
`else
            OP_JZ, OP_JC: nextPc_s = pc + PC_ONE;
`endif
            OP_HALT: begin
                isHalt_s = 1'b1;
                nextPc_s = pc;
            end
            default: nextPc_s = pc + PC_ONE;
        endcase
    end

    // Sequencer, architectural state and registered status outputs.
    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            state_r      <= FETCH;
            instr_r      <= '0;
            pc           <= '0;
            zeroFlag     <= 1'b0;
            carryFlag    <= 1'b0;
            halted       <= 1'b0;
            instrRequest <= 1'b1;
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                registers_r[i] <= '0;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (instrValid) begin
                        instr_r      <= instruction;
                        state_r      <= EXECUTE;
                        instrRequest <= 1'b0;
                    end
                end
                EXECUTE: begin
                    pc <= nextPc_s;
                    if (writeEn_s && (rd_s != '0)) begin
                        registers_r[rd_s] <= result_s[REGISTER_WIDTH-1:0];
                    end
                    if (flagEn_s) begin
                        zeroFlag  <= (result_s[REGISTER_WIDTH-1:0] == '0);
                        carryFlag <= result_s[REGISTER_WIDTH];
                    end
                    if (isHalt_s) begin
                        state_r      <= HALT;
                        halted       <= 1'b1;
                        instrRequest <= 1'b0;
                    end else begin
                        state_r      <= FETCH;
                        instrRequest <= 1'b1;
                    end
                end
                HALT: begin
                    halted       <= 1'b1;
                    instrRequest <= 1'b0;
                end
                default: begin
                    state_r      <= FETCH;
                    halted       <= 1'b0;
                    instrRequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Randomised self-checking bench for multicycle_cpu against an arithmetic reference model.
module tb_multicycle_cpu;

    logic        clock = 1'b0;
    logic        isReset;
    logic        instrRequest;
    logic [7:0]  pc;
    logic        instrValid;
    logic [17:0] instruction;
    logic [7:0]  switch;
    logic [2:0]  debugSelect;
    logic [7:0]  register1Value;
    logic        zeroFlag;
    logic        carryFlag;
    logic        halted;

    int total = 0;
    int bad   = 0;

    int mregs [8];
    int mpc;
    int mz;
    int mc;
    int mhalt;

    multicycle_cpu #(
        .REGISTER_WIDTH(8),
        .NUMBER_OF_REGISTERS(8),
        .PC_WIDTH(8)
    ) dut (
        .clock(clock),
        .isReset(isReset),
        .instrRequest(instrRequest),
        .pc(pc),
        .instrValid(instrValid),
        .instruction(instruction),
        .switch(switch),
        .debugSelect(debugSelect),
        .register1Value(register1Value),
        .zeroFlag(zeroFlag),
        .carryFlag(carryFlag),
        .halted(halted)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] enc(input int op, input int rd, input int rs, input int imm);
        return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        mpc = 0; mz = 0; mc = 0; mhalt = 0;
    endtask

    // Reference semantics written directly from the instruction set description.
    task automatic modelExec(input int op, input int rd, input int rs, input int imm, input int sw);
        int a, b, r, wr, fl, jmp;
        a = mregs[rd]; b = mregs[rs]; r = 0; wr = 0; fl = 0; jmp = 0;
        case (op)
            1:  begin r = imm; wr = 1; end
            2:  begin r = sw;  wr = 1; end
            3:  begin r = a + b; mc = (r > 255); r = r % 256; wr = 1; fl = 1; end
            4:  begin r = b + 1; mc = (r > 255); r = r % 256; wr = 1; fl = 1; end
            5:  begin mc = (b == 0); r = (b + 255) % 256; wr = 1; fl = 1; end
            6:  begin mc = (b >= 128); r = (b * 2) % 256; wr = 1; fl = 1; end
            7:  begin mc = b % 2; r = b / 2; wr = 1; fl = 1; end
            8:  begin mpc = imm; jmp = 1; end
            9:  begin mpc = b; jmp = 1; end
`ifdef COND_BRANCH_EN
            10: if (mz != 0) begin mpc = imm; jmp = 1; end
            11: if (mc != 0) begin mpc = imm; jmp = 1; end
`endif
            15: begin mhalt = 1; jmp = 1; end
            default: ;
        endcase
        if (fl != 0) mz = (r == 0);
        if (wr != 0 && rd != 0) mregs[rd] = r;
        if (jmp == 0) mpc = (mpc + 1) % 256;
    endtask

    task automatic checkRegs(input string tag);
        instrValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            debugSelect = i[2:0];
            #1;
            total++;
            if (register1Value !== mregs[i][7:0]) begin
                bad++;
                $display("FAIL %s r%0d got=%0h exp=%0h", tag, i, register1Value, mregs[i][7:0]);
            end
        end
        @(negedge clock);
    endtask

    // Issue one instruction from FETCH with a given number of fetch wait cycles.
    task automatic runInstr(input int op, input int rd, input int rs, input int imm,
                            input int waits, input string tag);
        int sw;
        sw = $urandom_range(0, 255);
        switch = sw[7:0];
        for (int w = 0; w < waits; w++) begin
            instrValid = 1'b0;
            instruction = 18'($urandom);
            @(negedge clock);
            debugSelect = rd[2:0];
            #1;
            total++;
            if (instrRequest !== 1'b1 || pc !== mpc[7:0] || register1Value !== mregs[rd][7:0]) begin
                bad++;
                $display("FAIL %s wait%0d req=%b pc=%0h r=%0h exp req=1 pc=%0h r=%0h",
                         tag, w, instrRequest, pc, register1Value, mpc[7:0], mregs[rd][7:0]);
            end
        end
        instrValid = 1'b1;
        instruction = enc(op, rd, rs, imm);
        @(negedge clock);
        total++;
        if (instrRequest !== 1'b0) begin
            bad++;
            $display("FAIL %s execReq got=%b exp=0", tag, instrRequest);
        end
        instruction = 18'($urandom);
        @(negedge clock);
        instrValid = 1'b0;
        modelExec(op, rd, rs, imm, sw);
        debugSelect = rd[2:0];
        #1;
        total++;
        if (pc !== mpc[7:0]) begin
            bad++; $display("FAIL %s pc got=%0h exp=%0h", tag, pc, mpc[7:0]);
        end
        total++;
        if (zeroFlag !== mz[0] || carryFlag !== mc[0]) begin
            bad++; $display("FAIL %s flags got=z%b c%b exp=z%b c%b", tag, zeroFlag, carryFlag, mz[0], mc[0]);
        end
        total++;
        if (halted !== mhalt[0] || instrRequest !== !mhalt[0]) begin
            bad++; $display("FAIL %s state got=halt%b req%b exp=halt%b", tag, halted, instrRequest, mhalt[0]);
        end
        total++;
        if (register1Value !== mregs[rd][7:0]) begin
            bad++; $display("FAIL %s rd got=%0h exp=%0h", tag, register1Value, mregs[rd][7:0]);
        end
    endtask

    task automatic pulseResetChecks(input string tag);
        @(negedge clock);
        isReset = 1'b1;
        #1;
        modelReset();
        total++;
        if (instrRequest !== 1'b1 || pc !== 8'h00 || halted !== 1'b0 || zeroFlag !== 1'b0 || carryFlag !== 1'b0) begin
            bad++;
            $display("FAIL %s req=%b pc=%0h halt=%b z=%b c=%b exp req=1 pc=0 halt=0 z=0 c=0",
                     tag, instrRequest, pc, halted, zeroFlag, carryFlag);
        end
        checkRegs(tag);
        isReset = 1'b0;
    endtask

    task automatic test_reset();
        pulseResetChecks("reset");
    endtask

    task automatic test_inc_wrap();
        runInstr(1, 1, 0, 8'hFF, 0, "load_ff");
        runInstr(4, 2, 1, 0, 0, "inc_wrap");
        total++;
        if (register1Value !== 8'h00 || zeroFlag !== 1'b1 || carryFlag !== 1'b1 || pc !== 8'h02) begin
            bad++; $display("FAIL inc_const r2=%0h z=%b c=%b pc=%0h exp 0 1 1 2", register1Value, zeroFlag, carryFlag, pc);
        end
    endtask

    task automatic test_fetch_wait();
        runInstr(1, 6, 0, 8'h5A, 3, "fetch_wait");
    endtask

    task automatic test_pc_wrap();
        runInstr(8, 0, 0, 8'hFF, 0, "jump_ff");
        runInstr(0, 0, 0, 0, 0, "nop_wrap");
        total++;
        if (pc !== 8'h00) begin
            bad++; $display("FAIL pc_wrap got=%0h exp=00", pc);
        end
    endtask

    task automatic test_reg0();
        runInstr(1, 0, 0, 8'h55, 0, "load_r0");
        runInstr(5, 3, 0, 0, 1, "dec_r0");
        checkRegs("reg0");
    endtask

    task automatic test_cond_branch();
        runInstr(1, 1, 0, 1, 0, "cb_load");
        runInstr(5, 1, 1, 0, 0, "cb_dec");
        runInstr(10, 0, 0, 8'h10, 0, "jz");
        runInstr(11, 0, 0, 8'h30, 0, "jc_not");
        runInstr(5, 3, 2, 0, 0, "cb_borrow");
        runInstr(11, 0, 0, 8'h40, 0, "jc_taken");
        runInstr(10, 0, 0, 8'h50, 0, "jz_not");
    endtask

    task automatic test_back_to_back();
        runInstr(1, 4, 0, 8'h81, 0, "b2b_load");
        runInstr(3, 4, 4, 0, 0, "b2b_add1");
        runInstr(3, 4, 4, 0, 0, "b2b_add2");
        runInstr(7, 5, 4, 0, 0, "b2b_rsh");
        runInstr(6, 5, 5, 0, 0, "b2b_lsh");
        runInstr(2, 7, 0, 0, 0, "b2b_sw");
        runInstr(9, 0, 7, 0, 0, "b2b_jreg");
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            runInstr($urandom_range(0, 14), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 255), $urandom_range(0, 2), "rand");
            if (n % 25 == 24) checkRegs("rand_regs");
        end
    endtask

    task automatic test_reset_mid();
        runInstr(1, 5, 0, 8'h3C, 0, "pre_mid");
        instrValid = 1'b1;
        instruction = enc(1, 6, 0, 8'hA5);
        @(negedge clock);
        pulseResetChecks("reset_exec");
        runInstr(4, 2, 0, 0, 0, "post_mid");
        instrValid = 1'b0;
        @(negedge clock);
        pulseResetChecks("reset_fetch");
    endtask

    task automatic test_halt();
        runInstr(1, 3, 0, 8'h77, 0, "pre_halt");
        runInstr(15, 0, 0, 0, 0, "halt");
        for (int i = 0; i < 10; i++) begin
            instrValid = 1'b1;
            instruction = enc(1, 3, 0, i);
            @(negedge clock);
            total++;
            if (halted !== 1'b1 || instrRequest !== 1'b0 || pc !== mpc[7:0]) begin
                bad++; $display("FAIL halt_hold halt=%b req=%b pc=%0h exp 1 0 %0h", halted, instrRequest, pc, mpc[7:0]);
            end
        end
        checkRegs("halt_regs");
        pulseResetChecks("halt_reset");
        runInstr(1, 1, 0, 8'h12, 0, "after_halt");
    endtask

    initial begin
        isReset = 1'b1;
        instrValid = 1'b0;
        instruction = '0;
        switch = '0;
        debugSelect = '0;
        modelReset();
        repeat (2) @(negedge clock);
        test_reset();
        test_inc_wrap();
        test_fetch_wait();
        test_pc_wrap();
        test_reg0();
        test_cond_branch();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 8, meaning data/register/immediate width.
REQ-002 SHALL have parameter NUMBER_OF_REGISTERS, default 8 (power of two, >=2), meaning register file depth; REG_ADDR_WIDTH = clog2(NUMBER_OF_REGISTERS).
REQ-003 SHALL have parameter PC_WIDTH, default 8, meaning instruction address width.
REQ-004 SHALL derive INSTRUCTION_WIDTH = 4 + 2*REG_ADDR_WIDTH + REGISTER_WIDTH; fields MSB-first: opCode[3:0], registerOut (rd), register2In (rs), instructionValue (imm).
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 isReset  input  1  reset, asynchronous, active-high.
REQ-007 instrRequest  output  1  fetch request to instruction memory.
REQ-008 pc  output  PC_WIDTH  fetch address / current program counter.
REQ-009 instrValid  input  1  instruction word valid this cycle.
REQ-010 instruction  input  INSTRUCTION_WIDTH  fetched instruction word.
REQ-011 switch  input  REGISTER_WIDTH  external switch value for LOADSWITCH.
REQ-012 debugSelect  input  REG_ADDR_WIDTH  register index for debug read.
REQ-013 register1Value  output  REGISTER_WIDTH  combinational read of registers[debugSelect].
REQ-014 zeroFlag, carryFlag  output  1 each  ALU status flags.
REQ-015 halted  output  1  core in HALT state.

Function
REQ-016 SHALL implement FSM states FETCH, EXECUTE, HALT; FETCH->EXECUTE when instrValid=1 (instruction latched same edge); EXECUTE->FETCH, or ->HALT on opCode HALT; HALT exits only by reset.
REQ-017 instrRequest SHALL be 1 exactly in FETCH; pc SHALL be stable while instrRequest=1; instrValid outside FETCH SHALL be ignored.
REQ-018 Each instruction SHALL take (fetch wait cycles + 2) cycles; minimum 2 when instrValid=1 in first FETCH cycle.
REQ-019 Opcodes: 0 NOP; 1 LOAD rd<=imm; 2 LOADSWITCH rd<=switch; 3 ADD rd<=rd+rs; 4 INC rd<=rs+1; 5 DECREMENT rd<=rs-1; 6 LSHIFT rd<=rs<<1; 7 RSHIFT rd<=rs>>1 logical; 8 JUMP pc<=imm; 9 JUMPREG pc<=rs; 10 JZ; 11 JC; 15 HALT; 12-14 SHALL execute as NOP.
REQ-020 Register writes and pc update SHALL occur on the EXECUTE-exit edge; non-jump instructions SHALL set pc<=pc+1 modulo 2^PC_WIDTH (wrap to 0).
REQ-021 Register 0 SHALL always read 0; writes to register 0 SHALL be discarded (flags still update).
REQ-022 Arithmetic SHALL be modulo 2^REGISTER_WIDTH; jump targets SHALL use the low PC_WIDTH bits of imm/rs, zero-extended if REGISTER_WIDTH<PC_WIDTH.
REQ-023 Opcodes 3-7 SHALL update flags: zeroFlag=(result==0); carryFlag=carry-out for ADD/INC, borrow for DECREMENT, shifted-out bit for LSHIFT/RSHIFT; other opcodes SHALL hold flags.
REQ-024 ADD with rd==rs SHALL use the pre-write value for both operands.

Reset
REQ-025 isReset=1 SHALL immediately force: state FETCH, pc=0, all registers 0, zeroFlag=0, carryFlag=0, halted=0; instrRequest SHALL read 1 while reset is held and restart the fetch of address 0 on release.
REQ-026 Reset asserted mid-fetch or mid-EXECUTE SHALL abort the instruction with no register/flag write.

Configuration
REQ-027 Macro COND_BRANCH_EN defined: JZ SHALL set pc<=imm when zeroFlag=1, JC when carryFlag=1, else pc<=pc+1.
REQ-028 COND_BRANCH_EN undefined: opcodes 10/11 SHALL execute as NOP (pc<=pc+1); flags SHALL still be computed and output.

Verification
REQ-029 Reset, instrValid=1 every cycle, program LOAD r1,0xFF; INC r2,r1 -> r2=0x00, zeroFlag=1, carryFlag=1, pc=2 after 4 cycles.
REQ-030 instrValid held 0 for 3 cycles in FETCH -> instrRequest stays 1, pc unchanged, no register change; instruction completes 5 cycles after fetch start.
REQ-031 pc=0xFF (PC_WIDTH=8) executing NOP -> pc=0x00 next fetch.
REQ-032 LOAD r0,0x55 then debugSelect=0 -> register1Value=0x00; DECREMENT r3,r0 -> r3=0xFF, carryFlag=1.
REQ-033 With COND_BRANCH_EN: DECREMENT r1 of 1 then JZ 0x10 -> pc=0x10; without macro -> pc=previous+1.
REQ-034 HALT executed -> halted=1, instrRequest=0 indefinitely; isReset pulse mid-HALT -> halted=0, pc=0, instrRequest=1.
